// File: rtl/pipelined_cla_adder.sv
// Two-stage carry-lookahead adder/subtractor with valid/ready on both sides.
// Optional saturation on signed overflow is enabled by defining CLA_SATURATE_EN.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
`ifdef CLA_SATURATE_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned NGRP = WIDTH / 4;

  // Handshake
  logic s1_valid_q, s2_valid_q;
  logic s1_adv, s2_adv, accept;

  assign s2_adv   = !s2_valid_q | out_ready;
  assign s1_adv   = !s1_valid_q | s2_adv;
  assign in_ready = s1_adv & !rst;
  assign accept   = in_valid & in_ready;

  // Stage 1: bitwise and group propagate/generate
  logic [WIDTH-1:0] bx, p_d, g_d;
  logic             ci_d;
  logic [NGRP-1:0]  gp_d, gg_d;

  always_comb begin
    bx   = sub ? ~b : b;
    ci_d = sub ? 1'b1 : c_in;
    p_d  = a ^ bx;
    g_d  = a & bx;
    gp_d = '0;
    gg_d = '0;
    for (int k = 0; k < int'(NGRP); k++) begin
      gp_d[k] = &p_d[4*k +: 4];
      gg_d[k] = g_d[4*k+3]
              | (p_d[4*k+3] & g_d[4*k+2])
              | (p_d[4*k+3] & p_d[4*k+2] & g_d[4*k+1])
              | (p_d[4*k+3] & p_d[4*k+2] & p_d[4*k+1] & g_d[4*k]);
    end
  end

  logic [WIDTH-1:0] p_q, g_q;
  logic [NGRP-1:0]  gp_q, gg_q;
  logic             ci_q, a_msb_q, bx_msb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      p_q        <= '0;
      g_q        <= '0;
      gp_q       <= '0;
      gg_q       <= '0;
      ci_q       <= 1'b0;
      a_msb_q    <= 1'b0;
      bx_msb_q   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= accept;
      // Data holds when the slot drains without a new beat
      if (accept) begin
        p_q      <= p_d;
        g_q      <= g_d;
        gp_q     <= gp_d;
        gg_q     <= gg_d;
        ci_q     <= ci_d;
        a_msb_q  <= a[WIDTH-1];
        bx_msb_q <= bx[WIDTH-1];
      end
    end
  end

`ifdef CLA_SATURATE_EN
  logic sat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (s1_adv && accept) begin
      sat_q <= sat;
    end
  end
`endif

  // Stage 2: second-level lookahead over groups, flattened so every group
  // carry is a sum of products of registered terms rather than a ripple.
  logic [NGRP:0] grp_c;

  always_comb begin
    logic acc;
    logic prod;
    acc      = 1'b0;
    prod     = 1'b0;
    grp_c    = '0;
    grp_c[0] = ci_q;
    for (int k = 0; k < int'(NGRP); k++) begin
      acc  = gg_q[k];
      prod = gp_q[k];
      for (int j = k - 1; j >= 0; j--) begin
        acc  = acc | (prod & gg_q[j]);
        prod = prod & gp_q[j];
      end
      grp_c[k+1] = acc | (prod & ci_q);
    end
  end

  // In-group carries from each group's carry-in
  logic [WIDTH-1:0] car;

  always_comb begin
    logic c0;
    c0  = 1'b0;
    car = '0;
    for (int k = 0; k < int'(NGRP); k++) begin
      c0         = grp_c[k];
      car[4*k]   = c0;
      car[4*k+1] = g_q[4*k] | (p_q[4*k] & c0);
      car[4*k+2] = g_q[4*k+1]
                 | (p_q[4*k+1] & g_q[4*k])
                 | (p_q[4*k+1] & p_q[4*k] & c0);
      car[4*k+3] = g_q[4*k+2]
                 | (p_q[4*k+2] & g_q[4*k+1])
                 | (p_q[4*k+2] & p_q[4*k+1] & g_q[4*k])
                 | (p_q[4*k+2] & p_q[4*k+1] & p_q[4*k] & c0);
    end
  end

  logic [WIDTH-1:0] sum_raw, sum_d;
  logic             ovf_d, zero_d, c_out_d;

  always_comb begin
    sum_raw = p_q ^ car;
    c_out_d = grp_c[NGRP];
    ovf_d   = (a_msb_q == bx_msb_q) & (sum_raw[WIDTH-1] != a_msb_q);
    sum_d   = sum_raw;
`ifdef CLA_SATURATE_EN
    // Clamp toward the sign of the operands; flags still describe the wrap
    if (sat_q && ovf_d) begin
      sum_d = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    zero_d = ~|sum_d;
  end

  logic [WIDTH-1:0] sum_q;
  logic             c_out_q, ovf_q, zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      c_out_q    <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sum_q   <= sum_d;
        c_out_q <= c_out_d;
        ovf_q   <= ovf_d;
        zero_q  <= zero_d;
      end
    end
  end

  logic [CNT_W-1:0] op_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q <= '0;
    end else if (s2_valid_q && out_ready) begin
      op_count_q <= op_count_q + CNT_W'(1);
    end
  end

  assign out_valid = s2_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder (WIDTH=32 main instance, WIDTH=4 side instance).
// Honours CLA_SATURATE_EN when defined.
module tb_pipelined_cla_adder;

`ifdef CLA_SATURATE_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, sub, c_in, sat;
  logic        out_valid, out_ready, c_out, ovf, zero;
  logic [31:0] a, b, sum;
  logic [15:0] op_count;

  logic        in_valid4, in_ready4, sub4, c_in4, sat4;
  logic        out_valid4, c_out4, ovf4, zero4;
  logic        out_ready4 = 1'b1;
  logic [3:0]  a4, b4, sum4;
  logic [15:0] op_count4;

  pipelined_cla_adder #(.WIDTH(32), .CNT_W(16)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .c_in     (c_in),
`ifdef CLA_SATURATE_EN
    .sat      (sat),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .c_out    (c_out),
    .ovf      (ovf),
    .zero     (zero),
    .op_count (op_count)
  );

  pipelined_cla_adder #(.WIDTH(4), .CNT_W(16)) u_dut4 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid4),
    .in_ready (in_ready4),
    .a        (a4),
    .b        (b4),
    .sub      (sub4),
    .c_in     (c_in4),
`ifdef CLA_SATURATE_EN
    .sat      (sat4),
`endif
    .out_valid(out_valid4),
    .out_ready(out_ready4),
    .sum      (sum4),
    .c_out    (c_out4),
    .ovf      (ovf4),
    .zero     (zero4),
    .op_count (op_count4)
  );

  typedef struct packed {
    logic [31:0] sum;
    logic        c_out;
    logic        ovf;
    logic        zero;
  } res_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic on w-bit operands
  function automatic res_t model(input int w, input longint unsigned ua, input longint unsigned ub,
                                 input bit s, input bit cin, input bit st);
    res_t r;
    longint unsigned md, half, u;
    longint sa, sb, ex;
    bit c;
    md   = 64'd1 << w;
    half = 64'd1 << (w - 1);
    sa   = (ua >= half) ? longint'(ua) - longint'(md) : longint'(ua);
    sb   = (ub >= half) ? longint'(ub) - longint'(md) : longint'(ub);
    if (s) begin
      ex = sa - sb;
      c  = (ua >= ub);
      u  = (ua - ub) & (md - 1);
    end else begin
      ex = sa + sb + longint'(cin);
      u  = ua + ub + 64'(cin);
      c  = (u >= md);
      u  = u & (md - 1);
    end
    r.ovf = (ex >= longint'(half)) || (ex < -longint'(half));
    if (st && r.ovf) u = (ex < 0) ? half : half - 1;
    r.sum   = 32'(u);
    r.c_out = c;
    r.zero  = (u == 0);
    return r;
  endfunction

  // Scoreboard and monitor
  res_t        exp_q[$];
  int          accepted_cnt = 0;
  int          delivered_cnt = 0;
  logic [15:0] model_count = '0;
  bit          hold_valid = 1'b0;
  logic [34:0] hold_val;

  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      exp_q.delete();
      model_count = '0;
      hold_valid  = 1'b0;
    end else begin
      if (hold_valid) begin
        chk("hold_out_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'({sum, c_out, ovf, zero}), 64'(hold_val));
      end
      hold_valid = out_valid & !out_ready;
      hold_val   = {sum, c_out, ovf, zero};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got %0h, expected no result", sum);
        end else begin
          e = exp_q.pop_front();
          chk("result", 64'({sum, c_out, ovf, zero}), 64'(e));
        end
        model_count = model_count + 16'd1;
        delivered_cnt++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(32, 64'(a), 64'(b), sub, c_in, SatEn && sat));
        accepted_cnt++;
      end
    end
  end

  task automatic drive_op(input logic [31:0] aa, input logic [31:0] bb, input bit s, input bit ci,
                          input bit st);
    a = aa; b = bb; sub = s; c_in = ci; sat = st;
  endtask

  task automatic drive_rand();
    logic [31:0] ra, rb;
    ra = $urandom;
    rb = $urandom;
    case ($urandom_range(0, 7))
      0: ra = 32'hFFFF_FFFF;
      1: rb = ra;
      2: ra = 32'h8000_0000;
      3: begin ra = 32'h7FFF_FFFF; rb = 32'h0000_0001; end
      default: ;
    endcase
    drive_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
  endtask

  task automatic run4(input logic [3:0] aa, input logic [3:0] bb, input bit s, input bit ci);
    res_t e;
    int   n;
    e = model(4, 64'(aa), 64'(bb), s, ci, 1'b0);
    a4 = aa; b4 = bb; sub4 = s; c_in4 = ci; sat4 = 1'b0; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    n = 0;
    while (!out_valid4 && n < 5) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w4_latency", 64'(n), 64'd1);
    chk("w4_sum", 64'(sum4), 64'(e.sum[3:0]));
    chk("w4_flags", 64'({c_out4, ovf4, zero4}), 64'({e.c_out, e.ovf, e.zero}));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, acc0, last;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive_op(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    in_valid4 = 1'b0; a4 = '0; b4 = '0; sub4 = 1'b0; c_in4 = 1'b0; sat4 = 1'b0;

    repeat (3) begin
      @(posedge clk); #2;
      chk("in_ready_in_reset", 64'(in_ready), 64'd0);
    end
    chk("out_valid_in_reset", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_reset_out_valid", 64'(out_valid), 64'd0);
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);
    chk("post_reset_op_count", 64'(op_count), 64'd0);
    chk("post_reset_data", 64'({sum, c_out, ovf, zero}), 64'd0);

    // Back-to-back burst of 8
    out_ready = 1'b1;
    d0 = delivered_cnt;
    for (int i = 0; i < 8; i++) begin
      drive_rand();
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #2;
    chk("burst_delivered_7", 64'(delivered_cnt - d0), 64'd7);
    @(negedge clk); #1;
    chk("burst_delivered_8", 64'(delivered_cnt - d0), 64'd8);
    @(posedge clk); #2;
    chk("burst_op_count", 64'(op_count), 64'd8);

    // Directed corner cases
    drive_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    drive_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    chk("add_wrap_valid", 64'(out_valid), 64'd1);
    chk("add_wrap_sum", 64'(sum), 64'd0);
    chk("add_wrap_flags", 64'({c_out, ovf, zero}), 64'b101);
    @(posedge clk); #2;
    chk("sub_ovf_sum", 64'(sum), SatEn ? 64'h8000_0000 : 64'h7FFF_FFFF);
    chk("sub_ovf_flags", 64'({c_out, ovf, zero}), 64'b110);
    @(posedge clk); #1;

    // Backpressure: pipe fills with exactly two ops
    out_ready = 1'b0;
    acc0 = accepted_cnt;
    last = accepted_cnt;
    drive_rand();
    in_valid = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (accepted_cnt != last) begin
        last = accepted_cnt;
        drive_rand();
      end
    end
    #1;
    chk("bp_accepted", 64'(accepted_cnt - acc0), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    d0 = delivered_cnt;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", 64'(in_ready), 64'd1);
    @(posedge clk); #2;
    chk("bp_no_gap", 64'(out_valid), 64'd1);
    @(posedge clk); #2;
    chk("bp_drained", 64'(delivered_cnt - d0), 64'd2);
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Reset with two ops in flight
    drive_rand();
    in_valid = 1'b1;
    @(posedge clk); #1;
    drive_rand();
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_no_stale", 64'(delivered_cnt - d0), 64'd2);
    drive_rand();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_new_op_not_early", 64'(out_valid), 64'd0);
    @(posedge clk); #2;
    chk("rst_new_op_latency", 64'(out_valid), 64'd1);
    @(posedge clk); #2;
    chk("rst_new_op_count", 64'(op_count), 64'd1);

    // Random traffic with random backpressure
    repeat (400) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive_rand();
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk); #2;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("final_op_count", 64'(op_count), 64'(model_count));

    // WIDTH=4 instance
    run4(4'hF, 4'h0, 1'b0, 1'b1);
    run4(4'h7, 4'h1, 1'b0, 1'b0);
    run4(4'h0, 4'h1, 1'b1, 1'b0);
    run4(4'h5, 4'h5, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run4(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
Parametrised two-stage carry-lookahead adder/subtractor for the ALU datapath. Stage 1 forms bitwise and 4-bit-group propagate/generate terms. Stage 2 resolves group carries with a second lookahead level, then forms sum and flags. Valid/ready handshakes on both sides give full throughput (one op per cycle) and full backpressure support.

Parameters:
WIDTH, 32, operand width; multiple of 4, legal range 4..64
CNT_W, 16, width of the completed-operation counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  1: A - B (B inverted, carry-in forced 1); 0: A + B + c_in
c_in  input  1  carry-in, used only when sub=0
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
c_out  output  1  carry out of MSB; for sub, 1 = no borrow
ovf  output  1  signed overflow
zero  output  1  sum == 0
op_count  output  CNT_W  number of results delivered (out_valid & out_ready)

Behaviour:
- Synchronous reset: s1_valid=0, s2_valid=0, all data/flag registers=0, op_count=0. While rst=1, in_ready=0. After rst deasserts: out_valid=0, in_ready=1.
- Effective B: bx = sub ? ~b : b. Effective carry-in: ci = sub ? 1 : c_in.
- Stage 1, on accept (in_valid & in_ready): register p=a^bx, g=a&bx, ci, a[MSB], bx[MSB].
- Stage 1 also registers group terms per 4-bit group k: GP[k]=&p[4k+3:4k]; GG[k]=g3|p3g2|p3p2g1|p3p2p1g0.
- Stage 2: group carry C[0]=ci; C[k+1]=GG[k]|(GP[k]&C[k]), flattened as lookahead. In-group carries use the 4-bit lookahead equations from C[k]. sum=p^carries.
- Stage 2 flags: c_out=C[WIDTH/4]; ovf=(a_msb==bx_msb)&(sum[MSB]!=a_msb); zero=(sum==0). All registered with the result.
- Latency: 2 cycles from accept to out_valid with no stall. Throughput: 1 op/cycle.
- Handshake:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv & !rst (combinational path from out_ready is permitted).
- While out_valid=1 and out_ready=0, sum/c_out/ovf/zero hold stable. A full pipe holds 2 ops with no loss or duplication.
- Simultaneous accept and deliver in the same cycle: both take effect; occupancy is unchanged.
- in_valid=0 with s1 advancing: s1_valid clears and stage-1 data registers hold.
- op_count increments on out_valid & out_ready and wraps modulo 2^CNT_W.
- rst asserted mid-operation: in-flight ops are discarded and no result is emitted. Clears on the same edge as the reset state.
- Operands are unsigned/two's complement agnostic. ovf is meaningful for signed operands; c_out is meaningful for unsigned.

Optional Feature:
CLA_SATURATE_EN.
- Defined: adds input port sat (1 bit), registered in stage 1 alongside the operands. When sat=1 and ovf=1, sum clamps to 0111..1 if a_msb=0, else 1000..0. zero is computed on the clamped value. ovf and c_out still report the unclamped condition.
- Undefined: no sat port, no clamping logic; sum is always the wrapped result.

Test Plan:
- WIDTH=32, add, a=0x0000_0001, b=0xFFFF_FFFF, c_in=0 -> after 2 cycles sum=0, c_out=1, zero=1, ovf=0.
- sub, a=0x8000_0000, b=0x0000_0001 -> sum=0x7FFF_FFFF, ovf=1, c_out=1. With CLA_SATURATE_EN and sat=1 -> sum=0x8000_0000, ovf=1.
- Back-to-back stream of 8 random ops with out_ready=1 -> 8 results on consecutive cycles, in order, matching a golden model; op_count=8.
- Hold out_ready=0 with in_valid=1 continuously -> exactly 2 ops accepted, then in_ready=0. Result stays stable. On out_ready=1, both results drain in order with no gap, and in_ready goes high the same cycle.
- Assert rst for 1 cycle with 2 ops in flight -> out_valid=0 the next cycle, op_count=0, no stale result ever appears; a new op after reset returns after 2 cycles.
- WIDTH=4, add, a=0xF, b=0x0, c_in=1 -> sum=0x0, c_out=1, zero=1 (full group-propagate chain exercised).
